// File: rtl/ep_temporal_blend.sv
// ep_temporal_blend
//   Edge-preserving temporal noise filter. Each channel of the current pixel
//   is pulled toward the co-located previous-frame filtered pixel. The pull
//   is full strength for small differences, half strength in the middle band,
//   and zero at edges/motion. A per-frame count of edge channels is kept.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   cfg_bypass         1: output = cur (edge flags still produced)
//   cfg_strength       max blend weight, clamped to 2^WB
//   cfg_noise_th       |cur-prev| below this -> full strength
//   cfg_edge_th        |cur-prev| at/above this -> edge, no blend
//   in_valid/in_ready  input handshake; in_sof marks first pixel of a frame
//   in_cur, in_prev    current and previous-frame pixels (ch0 in LSBs)
//   out_valid/out_ready output handshake; out_sof travels with its beat
//   out_pix, out_edge  filtered pixel and per-channel edge flags
//   edge_cnt_last      edge-channel count of the last completed frame
module ep_temporal_blend #(
  parameter int N     = 8,
  parameter int CH    = 1,
  parameter int WB    = 4,
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_bypass,
  input  logic [WB:0]       cfg_strength,
  input  logic [N-1:0]      cfg_noise_th,
  input  logic [N-1:0]      cfg_edge_th,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [CH*N-1:0]   in_cur,
  input  logic [CH*N-1:0]   in_prev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [CH*N-1:0]   out_pix,
  output logic [CH-1:0]     out_edge,
  output logic [CNT_W-1:0]  edge_cnt_last
);

  localparam int PW = N + WB + 2;
  localparam logic [WB:0]           FULL_W  = (WB+1)'(2**WB);
  localparam logic signed [PW-1:0]  HALF    = PW'(2**(WB-1));
  localparam logic signed [PW-1:0]  PIX_MAX = PW'(2**N - 1);
  localparam logic [CNT_W:0]        CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  function automatic logic [N-1:0] round_sat(input logic [N-1:0] cur,
                                             input logic signed [PW-1:0] p);
    logic signed [PW-1:0] y;
    y = $signed(PW'(cur)) + ((p + HALF) >>> WB);
    if (y < 0)            return '0;
    else if (y > PIX_MAX) return '1;
    else                  return y[N-1:0];
  endfunction

  function automatic logic [CNT_W:0] popcount(input logic [CH-1:0] e);
    logic [CNT_W:0] n;
    n = '0;
    for (int c = 0; c < CH; c++) n = n + (CNT_W+1)'(e[c]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + b;
    return (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  // The whole pipeline advances together; bubbles are carried, not collapsed.
  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en && !rst;

  // ---- Stage 1: absolute and signed difference, capture cfg with the beat
  logic [N-1:0]        w_diff_s1 [CH];
  logic signed [N:0]   w_d_s1    [CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_d_s1[c]    = $signed({1'b0, in_prev[c*N +: N]}) - $signed({1'b0, in_cur[c*N +: N]});
      w_diff_s1[c] = (in_prev[c*N +: N] > in_cur[c*N +: N]) ?
                     in_prev[c*N +: N] - in_cur[c*N +: N] :
                     in_cur[c*N +: N] - in_prev[c*N +: N];
    end
  end

  logic                r_vld_p1, r_sof_p1, r_byp_p1;
  logic [WB:0]         r_str_p1;
  logic [N-1:0]        r_nth_p1, r_eth_p1;
  logic [CH*N-1:0]     r_cur_p1;
  logic [N-1:0]        r_diff_p1 [CH];
  logic signed [N:0]   r_d_p1    [CH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_sof_p1 <= in_sof;
      r_byp_p1 <= cfg_bypass;
      r_str_p1 <= cfg_strength;
      r_nth_p1 <= cfg_noise_th;
      r_eth_p1 <= cfg_edge_th;
      r_cur_p1 <= in_cur;
      for (int c = 0; c < CH; c++) begin
        r_diff_p1[c] <= w_diff_s1[c];
        r_d_p1[c]    <= w_d_s1[c];
      end
    end
  end

  // ---- Stage 2: weight selection and weighted difference
  logic [WB:0]          w_s_s2;
  logic [WB:0]          w_w_s2    [CH];
  logic signed [PW-1:0] w_p_s2    [CH];
  logic [CH-1:0]        w_edge_s2;

  always_comb begin
    w_s_s2    = (r_str_p1 > FULL_W) ? FULL_W : r_str_p1;
    w_edge_s2 = '0;
    for (int c = 0; c < CH; c++) begin
      // Edge test comes first so it wins even when noise_th >= edge_th.
      w_edge_s2[c] = (r_diff_p1[c] >= r_eth_p1);
      if (w_edge_s2[c] || r_byp_p1)        w_w_s2[c] = '0;
      else if (r_diff_p1[c] < r_nth_p1)    w_w_s2[c] = w_s_s2;
      else                                 w_w_s2[c] = w_s_s2 >> 1;
      w_p_s2[c] = PW'(r_d_p1[c]) * PW'($signed({1'b0, w_w_s2[c]}));
    end
  end

  logic                 r_vld_p2, r_sof_p2;
  logic [CH*N-1:0]      r_cur_p2;
  logic [CH-1:0]        r_edge_p2;
  logic signed [PW-1:0] r_p_p2 [CH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_sof_p2  <= r_sof_p1;
      r_cur_p2  <= r_cur_p1;
      r_edge_p2 <= w_edge_s2;
      for (int c = 0; c < CH; c++) r_p_p2[c] <= w_p_s2[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- Stage 3: round, add back to cur, clamp to pixel range
  logic [CH*N-1:0] w_pix_s3;

  always_comb begin
    w_pix_s3 = '0;
    for (int c = 0; c < CH; c++)
      w_pix_s3[c*N +: N] = round_sat(r_cur_p2[c*N +: N], r_p_p2[c]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= '0;
      out_edge  <= '0;
    end else if (w_en) begin
      out_valid <= r_vld_p2;
      out_sof   <= r_sof_p2;
      out_pix   <= w_pix_s3;
      out_edge  <= r_edge_p2;
    end
  end

  // ---- Edge statistics, counted on output handshakes
  logic             w_hs;
  logic [CNT_W:0]   w_pc;
  logic [CNT_W-1:0] r_run_cnt;

  assign w_hs = out_valid && out_ready;
  assign w_pc = popcount(out_edge);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt     <= '0;
      edge_cnt_last <= '0;
    end else if (w_hs) begin
      if (out_sof) begin
        // The sof beat belongs to the new frame: publish the old total first.
        edge_cnt_last <= r_run_cnt;
        r_run_cnt     <= sat_add('0, w_pc);
      end else begin
        r_run_cnt     <= sat_add(r_run_cnt, w_pc);
      end
    end
  end

endmodule

// File: tb/tb_ep_temporal_blend.sv
module tb_ep_temporal_blend;
  localparam int N     = 8;
  localparam int CH    = 1;
  localparam int WB    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cfg_bypass;
  logic [WB:0]       cfg_strength;
  logic [N-1:0]      cfg_noise_th, cfg_edge_th;
  logic              in_valid, in_ready, in_sof;
  logic [CH*N-1:0]   in_cur, in_prev;
  logic              out_valid, out_ready, out_sof;
  logic [CH*N-1:0]   out_pix;
  logic [CH-1:0]     out_edge;
  logic [CNT_W-1:0]  edge_cnt_last;

  ep_temporal_blend #(.N(N), .CH(CH), .WB(WB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass), .cfg_strength(cfg_strength),
    .cfg_noise_th(cfg_noise_th), .cfg_edge_th(cfg_edge_th),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_cur(in_cur), .in_prev(in_prev),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_pix(out_pix), .out_edge(out_edge), .edge_cnt_last(edge_cnt_last)
  );

  typedef struct {
    logic [7:0] pix;
    logic       edg;
    logic       sof;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference: floor((d*w + 8)/16) computed with integer division.
  function automatic exp_t model(input int cur, input int prev, input bit sof);
    exp_t e;
    int diff, s, w, q, r, y;
    diff  = (cur > prev) ? cur - prev : prev - cur;
    s     = (int'(cfg_strength) > 16) ? 16 : int'(cfg_strength);
    e.edg = (diff >= int'(cfg_edge_th));
    if (e.edg || cfg_bypass)           w = 0;
    else if (diff < int'(cfg_noise_th)) w = s;
    else                               w = s / 2;
    q = (prev - cur) * w + 8;
    r = (q >= 0) ? q / 16 : -((15 - q) / 16);
    y = cur + r;
    if (y < 0)   y = 0;
    if (y > 255) y = 255;
    e.pix = 8'(y);
    e.sof = sof;
    return e;
  endfunction

  task automatic set_cfg(input bit byp, input int str, input int nth, input int eth);
    cfg_bypass   = byp;
    cfg_strength = 5'(str);
    cfg_noise_th = 8'(nth);
    cfg_edge_th  = 8'(eth);
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Offers one beat; the expectation is queued at the edge it is accepted.
  task automatic send(input int cur, input int prev, input bit sof);
    exp_t e;
    bit   done;
    done     = 1'b0;
    e        = model(cur, prev, sof);
    in_cur   = 8'(cur);
    in_prev  = 8'(prev);
    in_sof   = sof;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL send_accept: in_ready=%0b, required 1 within 100 cycles", in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sof !== 1'b0 ||
        out_pix !== 8'd0 || out_edge !== 1'b0 || edge_cnt_last !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%0b vld=%0b sof=%0b pix=%0d edge=%0b last=%0d, required all 0",
               in_ready, out_valid, out_sof, out_pix, out_edge, edge_cnt_last);
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_blend();
    int   cur_t [2] = '{100, 110};
    int   prev_t[2] = '{110, 100};
    int   want_t[2] = '{105, 105};
    exp_t e;
    int   lat;
    bit   got;
    sync();
    set_cfg(0, 8, 20, 60);
    for (int i = 0; i < 2; i++) begin
      send(cur_t[i], prev_t[i], 1'b0);
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk); lat++; got = out_valid;
      end
      vectors++;
      if (!got || lat != 3) begin
        miscompares++;
        $display("FAIL blend_latency[%0d]: got %0d cycles (valid=%0b), required 3", i, lat, got);
      end
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (out_pix !== e.pix || out_edge !== e.edg || out_pix !== 8'(want_t[i])) begin
          miscompares++;
          $display("FAIL blend_value[%0d]: pix=%0d edge=%0b, required pix=%0d edge=%0b",
                   i, out_pix, out_edge, want_t[i], e.edg);
        end
      end
      sync();
    end
  endtask

  task automatic test_bands();
    int   cur_t [7] = '{ 30, 255, 100, 100, 100, 100, 100};
    int   prev_t[7] = '{ 70,  50, 110, 120, 160, 170, 159};
    int   str_t [7] = '{  8,   8,  31,   8,   8,   8,   8};
    int   nth_t [7] = '{ 20,  20,  20,  20,  20,  80,  20};
    int   want_t[7] = '{ 40, 255, 110, 105, 100, 100, 115};
    bit   edg_t [7] = '{  0,   1,   0,   0,   1,   1,   0};
    exp_t e;
    int   lat;
    bit   got;
    sync();
    for (int i = 0; i < 7; i++) begin
      set_cfg(0, str_t[i], nth_t[i], 60);
      send(cur_t[i], prev_t[i], 1'b0);
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk); lat++; got = out_valid;
      end
      vectors++;
      if (!got || sb.size() == 0) begin
        miscompares++;
        $display("FAIL bands_timeout[%0d]: valid=%0b queued=%0d, required output", i, got, sb.size());
      end else begin
        e = sb.pop_front();
        if (out_pix !== e.pix || out_edge !== e.edg ||
            out_pix !== 8'(want_t[i]) || out_edge !== edg_t[i]) begin
          miscompares++;
          $display("FAIL bands[%0d]: pix=%0d edge=%0b, required pix=%0d edge=%0b",
                   i, out_pix, out_edge, want_t[i], edg_t[i]);
        end
      end
      sync();
    end
    set_cfg(0, 8, 20, 60);
  endtask

  task automatic test_bypass();
    int   cur_t [2] = '{30, 255};
    int   prev_t[2] = '{70,  50};
    int   want_t[2] = '{30, 255};
    bit   edg_t [2] = '{ 0,   1};
    exp_t e;
    int   lat;
    bit   got;
    sync();
    set_cfg(1, 8, 20, 60);
    for (int i = 0; i < 2; i++) begin
      send(cur_t[i], prev_t[i], 1'b0);
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk); lat++; got = out_valid;
      end
      vectors++;
      if (!got || sb.size() == 0) begin
        miscompares++;
        $display("FAIL bypass_timeout[%0d]: valid=%0b, required output", i, got);
      end else begin
        e = sb.pop_front();
        if (out_pix !== e.pix || out_edge !== e.edg ||
            out_pix !== 8'(want_t[i]) || out_edge !== edg_t[i]) begin
          miscompares++;
          $display("FAIL bypass[%0d]: pix=%0d edge=%0b, required pix=%0d edge=%0b",
                   i, out_pix, out_edge, want_t[i], edg_t[i]);
        end
      end
      sync();
    end
    set_cfg(0, 8, 20, 60);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   received;
    logic [7:0] held;
    bit   seen;
    received = 0;
    sync();
    set_cfg(0, 8, 20, 60);
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(20 + 30 * i, 20 + 30 * i + ((i % 2) ? -12 : 7), 1'b0);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk); seen = out_valid;
        end
        if (!seen) begin
          vectors++; miscompares++;
          $display("FAIL bp_start: out_valid never rose, required 1");
        end
        sync();
        out_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) held = out_pix;
          vectors++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pix !== held) begin
            miscompares++;
            $display("FAIL bp_stall[%0d]: vld=%0b rdy=%0b pix=%0d, required vld=1 rdy=0 pix=%0d",
                     k, out_valid, in_ready, out_pix, held);
          end
          sync();
        end
        out_ready = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 300 && received < 6; cyc++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL bp_extra: pix=%0d, required no beat", out_pix);
            end else begin
              e = sb.pop_front();
              if (out_pix !== e.pix || out_edge !== e.edg) begin
                miscompares++;
                $display("FAIL bp_beat[%0d]: pix=%0d edge=%0b, required pix=%0d edge=%0b",
                         received, out_pix, out_edge, e.pix, e.edg);
              end
            end
            received++;
          end
        end
      end
    join
    vectors++;
    if (received != 6 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: received %0d queued %0d, required 6 and 0", received, sb.size());
    end
  endtask

  task automatic test_edge_stats();
    exp_t e;
    int   received, exp_run, exp_last;
    bit   sof, edg;
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    set_cfg(0, 8, 20, 60);
    received = 0; exp_run = 0; exp_last = 0;
    fork
      begin
        for (int i = 0; i < 31; i++) begin
          sof = (i == 0 || i == 10 || i == 30);
          edg = (i == 2 || i == 5 || i == 8 || (i >= 10 && i < 30));
          if (edg) send(255, 0, sof);
          else     send(100 + i, 104 + i, sof);
        end
      end
      begin
        for (int cyc = 0; cyc < 400 && received < 31; cyc++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
              miscompares++;
              $display("FAIL stats_extra: pix=%0d, required no beat", out_pix);
            end else begin
              e = sb.pop_front();
              if (out_pix !== e.pix || out_edge !== e.edg || out_sof !== e.sof ||
                  edge_cnt_last !== 4'(exp_last)) begin
                miscompares++;
                $display("FAIL stats_beat[%0d]: pix=%0d edge=%0b sof=%0b last=%0d, required %0d %0b %0b %0d",
                         received, out_pix, out_edge, out_sof, edge_cnt_last,
                         e.pix, e.edg, e.sof, exp_last);
              end
              if (e.sof) begin
                exp_last = exp_run;
                exp_run  = int'(e.edg);
              end else begin
                exp_run = exp_run + int'(e.edg);
                if (exp_run > CMAX) exp_run = CMAX;
              end
            end
            received++;
          end
        end
      end
    join
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (received != 31 || edge_cnt_last !== 4'(CMAX)) begin
      miscompares++;
      $display("FAIL stats_saturate: received %0d last=%0d, required 31 and %0d",
               received, edge_cnt_last, CMAX);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int   lat;
    bit   got, stale;
    sync();
    set_cfg(0, 8, 20, 60);
    send(30, 70, 1'b0);
    send(100, 110, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_ready: got %0b, required 0", in_ready);
    end
    sync();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pix !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_rst_after: vld=%0b rdy=%0b pix=%0d, required 0 1 0",
               out_valid, in_ready, out_pix);
    end
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    vectors++;
    if (stale) begin
      miscompares++;
      $display("FAIL mid_rst_stale: out_valid=1 seen, required 0");
    end
    sync();
    send(60, 50, 1'b0);
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk); lat++; got = out_valid;
    end
    vectors++;
    if (!got || lat != 3 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL mid_rst_latency: got %0d cycles (valid=%0b), required 3", lat, got);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (out_pix !== e.pix || out_pix !== 8'd55 || out_edge !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_rst_value: pix=%0d edge=%0b, required 55 0", out_pix, out_edge);
      end
    end
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_cur    = '0;
    in_prev   = '0;
    out_ready = 1'b1;
    set_cfg(0, 8, 20, 60);
    test_reset();
    test_blend();
    test_bands();
    test_backpressure();
    test_edge_stats();
    test_bypass();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
